// File: rtl/nvdla_package.sv
// Shared TCDM types and widths for the NVDLA cluster-memory side.
package nvdla_package;

  localparam int TCDM_DATA_W = 32;
  localparam int TCDM_ADDR_W = 32;
  localparam int TCDM_BE_W   = 4;

  // One master-side request as seen by the responder.
  typedef struct packed {
    logic [TCDM_ADDR_W-1:0] add;
    logic                   wen;   // 1 = read, 0 = write
    logic [TCDM_BE_W-1:0]   be;
    logic [TCDM_DATA_W-1:0] data;
  } tcdm_req_t;

  // One response beat back to a master.
  typedef struct packed {
    logic [TCDM_DATA_W-1:0] r_data;
    logic                   r_valid;
  } tcdm_resp_t;

endpackage

// File: rtl/nvdla_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer (circularly); the pointer then moves to winner+1 and holds when idle.
module nvdla_rr_arbiter #(
  parameter int N = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] winner;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  // Pick the winner: first pass covers indices >= ptr, second pass wraps to 0.
  always_comb begin
    gnt     = '0;
    winner  = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        winner = PW'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        winner = PW'(i);
        found  = 1'b1;
      end
    end
    ptr_nxt = (winner == PW'(N - 1)) ? '0 : winner + PW'(1);
  end

  // Pointer register: advances only when a grant is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/nvdla_tcdm_responder.sv
// TCDM slave responder: word-interleaved banked SRAM with per-bank round-robin
// arbitration, same-cycle grant and a one-cycle registered response.
//
// Handshake: a master raises tcdm_req with its request fields stable; the
// access happens on the rising edge of the cycle in which tcdm_gnt is high
// (gnt is only ever high together with req). Un-granted masters keep req and
// fields stable until granted. Exactly one cycle after the grant, tcdm_r_valid
// pulses for one cycle with tcdm_r_data (read word, or 0 for writes); there is
// no back-pressure on the response.
module nvdla_tcdm_responder
  import nvdla_package::*;
#(
  parameter int MP         = 5,
  parameter int N_BANKS    = 4,
  parameter int BANK_WORDS = 256
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [MP-1:0]                    tcdm_req,
  output logic [MP-1:0]                    tcdm_gnt,
  input  logic [MP-1:0][TCDM_ADDR_W-1:0]   tcdm_add,
  input  logic [MP-1:0]                    tcdm_wen,
  input  logic [MP-1:0][TCDM_BE_W-1:0]     tcdm_be,
  input  logic [MP-1:0][TCDM_DATA_W-1:0]   tcdm_data,
  output logic [MP-1:0][TCDM_DATA_W-1:0]   tcdm_r_data,
  output logic [MP-1:0]                    tcdm_r_valid,
  input  logic [MP-1:0]                    stall_mask_i,
  output logic [15:0]                      conflict_cnt_o
);

  localparam int BANK_BITS = $clog2(N_BANKS);
  localparam int ROW_BITS  = $clog2(BANK_WORDS);
  localparam int ADDR_TOP  = 2 + BANK_BITS + ROW_BITS;

  tcdm_req_t              req_s    [MP];
  tcdm_resp_t             resp_q   [MP];
  logic [BANK_BITS-1:0]   bank_sel [MP];
  logic [ROW_BITS-1:0]    row_sel  [MP];
  logic [TCDM_DATA_W-1:0] rd_word  [MP];
  logic [MP-1:0]          bank_gnt [N_BANKS];
  logic [TCDM_DATA_W-1:0] mem      [N_BANKS][BANK_WORDS];
  logic [MP-1:0]          lost;
  logic                   unused_addr;

  // Bundle ports and decode bank/row; bits above the array size wrap away.
  always_comb begin
    unused_addr = 1'b0;
    for (int p = 0; p < MP; p++) begin
      req_s[p].add  = tcdm_add[p];
      req_s[p].wen  = tcdm_wen[p];
      req_s[p].be   = tcdm_be[p];
      req_s[p].data = tcdm_data[p];
      bank_sel[p]   = tcdm_add[p][2 +: BANK_BITS];
      row_sel[p]    = tcdm_add[p][2 + BANK_BITS +: ROW_BITS];
      rd_word[p]    = mem[bank_sel[p]][row_sel[p]];
      unused_addr   = unused_addr ^ (^{tcdm_add[p][1:0], tcdm_add[p][TCDM_ADDR_W-1:ADDR_TOP]});
    end
  end

  // One arbiter per bank; reset and stall keep a port out of contention.
  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [MP-1:0] cand;

    // Candidates for this bank.
    always_comb begin
      cand = '0;
      for (int p = 0; p < MP; p++) begin
        cand[p] = tcdm_req[p] & ~stall_mask_i[p] & ~rst_i & (bank_sel[p] == BANK_BITS'(b));
      end
    end

    nvdla_rr_arbiter #(.N(MP)) u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req   (cand),
      .gnt   (bank_gnt[b])
    );
  end

  // A port targets exactly one bank, so OR-ing bank grants stays one-per-port.
  always_comb begin
    tcdm_gnt = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      tcdm_gnt = tcdm_gnt | bank_gnt[b];
    end
    lost = tcdm_req & ~stall_mask_i & ~tcdm_gnt;
  end

  // Byte-masked SRAM writes on the granted edge; contents are not reset.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++) begin
      if (tcdm_gnt[p] && !req_s[p].wen) begin
        for (int k = 0; k < TCDM_BE_W; k++) begin
          if (req_s[p].be[k]) begin
            mem[bank_sel[p]][row_sel[p]][8*k +: 8] <= req_s[p].data[8*k +: 8];
          end
        end
      end
    end
  end

  // Response register: one-cycle pulse per grant, read data or zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < MP; p++) begin
        resp_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < MP; p++) begin
        resp_q[p].r_valid <= tcdm_gnt[p];
        resp_q[p].r_data  <= (tcdm_gnt[p] && req_s[p].wen) ? rd_word[p] : '0;
      end
    end
  end

  // Drive response ports from the registered structs.
  always_comb begin
    for (int p = 0; p < MP; p++) begin
      tcdm_r_valid[p] = resp_q[p].r_valid;
      tcdm_r_data[p]  = resp_q[p].r_data;
    end
  end

  // Saturating count of cycles in which some active request lost arbitration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
    end else if ((|lost) && (conflict_cnt_o != 16'hFFFF)) begin
      conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_nvdla_tcdm_responder.sv
// Self-checking bench for nvdla_tcdm_responder against a behavioural model.
module tb_nvdla_tcdm_responder;
  import nvdla_package::*;

  localparam int MP    = 5;
  localparam int NB    = 4;
  localparam int BW    = 256;
  localparam int WORDS = NB * BW;

  logic                  clk;
  logic                  rst;
  logic [MP-1:0]         req;
  logic [MP-1:0]         gnt;
  logic [MP-1:0][31:0]   add;
  logic [MP-1:0]         wen;
  logic [MP-1:0][3:0]    be;
  logic [MP-1:0][31:0]   wdata;
  logic [MP-1:0][31:0]   r_data;
  logic [MP-1:0]         r_valid;
  logic [MP-1:0]         stall;
  logic [15:0]           cnt;

  nvdla_tcdm_responder #(.MP(MP), .N_BANKS(NB), .BANK_WORDS(BW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tcdm_req       (req),
    .tcdm_gnt       (gnt),
    .tcdm_add       (add),
    .tcdm_wen       (wen),
    .tcdm_be        (be),
    .tcdm_data      (wdata),
    .tcdm_r_data    (r_data),
    .tcdm_r_valid   (r_valid),
    .stall_mask_i   (stall),
    .conflict_cnt_o (cnt)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference model ----------------
  int          ptr_m [NB];
  logic [31:0] mem_m [WORDS];
  logic [15:0] cnt_m;
  logic [MP-1:0] exp_valid;
  logic [31:0] exp_data [MP];
  logic [31:0] exp_q [$];

  int chk_cnt;
  int pass_cnt;

  logic [MP-1:0]       o_gnt;
  logic [MP-1:0]       o_valid;
  logic [MP-1:0][31:0] o_data;
  logic [15:0]         o_cnt;
  logic [MP-1:0]       e_gnt;

  // Byte address -> flat word index; the array wraps every WORDS*4 bytes.
  function automatic int word_of(input logic [31:0] a);
    return int'(a[31:2]) % WORDS;
  endfunction

  // Expected grants: per bank, first eligible port searching circularly from the pointer.
  function automatic logic [MP-1:0] model_gnt();
    logic [MP-1:0] g;
    g = '0;
    if (rst) return g;
    for (int b = 0; b < NB; b++) begin
      int best;
      best = -1;
      for (int k = 0; k < MP; k++) begin
        int p;
        p = (ptr_m[b] + k) % MP;
        if (best < 0 && req[p] && !stall[p] && (word_of(add[p]) % NB) == b) best = p;
      end
      if (best >= 0) g[best] = 1'b1;
    end
    return g;
  endfunction

  // Advance the model across one rising edge given the grants of the cycle.
  task automatic model_commit(input logic [MP-1:0] g);
    if (rst) begin
      for (int b = 0; b < NB; b++) ptr_m[b] = 0;
      cnt_m = '0;
      exp_valid = '0;
      for (int p = 0; p < MP; p++) exp_data[p] = '0;
      return;
    end
    for (int p = 0; p < MP; p++) begin
      exp_valid[p] = g[p];
      exp_data[p]  = (g[p] && wen[p]) ? mem_m[word_of(add[p])] : 32'h0;
      if (g[p]) exp_q.push_back(exp_data[p]);
    end
    for (int p = 0; p < MP; p++) begin
      if (g[p] && !wen[p]) begin
        for (int k = 0; k < 4; k++)
          if (be[p][k]) mem_m[word_of(add[p])][8*k +: 8] = wdata[p][8*k +: 8];
      end
      if (g[p]) ptr_m[word_of(add[p]) % NB] = (p + 1) % MP;
    end
    if ((|(req & ~stall & ~g)) && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req = '0; wen = '0; be = '0; wdata = '0; stall = '0;
    for (int p = 0; p < MP; p++) add[p] = '0;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d);
    req[p] = 1'b1; add[p] = a; wen[p] = w; be[p] = b; wdata[p] = d;
  endtask

  // One clock cycle: sample grants mid-cycle, then responses #1 after the edge.
  task automatic step();
    #2;
    e_gnt = model_gnt();
    o_gnt = gnt;
    @(posedge clk);
    model_commit(e_gnt);
    #1;
    o_valid = r_valid;
    o_data  = r_data;
    o_cnt   = cnt;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    req = '1;
    for (int p = 0; p < MP; p++) begin
      add[p] = $urandom; wen[p] = 1'($urandom_range(0, 1)); be[p] = 4'hF; wdata[p] = $urandom;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      chk_cnt++; if (o_gnt !== 5'b0) $display("FAIL reset_gnt: got %b want 00000", o_gnt); else pass_cnt++;
      chk_cnt++; if (o_valid !== 5'b0) $display("FAIL reset_valid: got %b want 00000", o_valid); else pass_cnt++;
      chk_cnt++; if (o_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", o_cnt); else pass_cnt++;
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_write_read();
    clear_inputs();
    set_port(0, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF);
    step();
    chk_cnt++; if (o_gnt !== 5'b00001 || o_gnt !== e_gnt) $display("FAIL wr_gnt: got %b want 00001", o_gnt); else pass_cnt++;
    chk_cnt++; if (o_valid[0] !== 1'b1 || o_data[0] !== 32'h0) $display("FAIL wr_resp: got v=%b d=%h want v=1 d=0", o_valid[0], o_data[0]); else pass_cnt++;
    clear_inputs();
    set_port(0, 32'h10, 1'b1, 4'h0, 32'h0);
    step();
    chk_cnt++; if (o_gnt !== 5'b00001) $display("FAIL rd_gnt: got %b want 00001", o_gnt); else pass_cnt++;
    chk_cnt++; if (o_valid !== 5'b00001 || o_data[0] !== 32'hDEADBEEF) $display("FAIL rd_data: got v=%b d=%h want v=00001 d=deadbeef", o_valid, o_data[0]); else pass_cnt++;
    clear_inputs();
    step();
    chk_cnt++; if (o_valid !== 5'b0) $display("FAIL rvalid_pulse: got %b want 00000", o_valid); else pass_cnt++;
  endtask

  task automatic test_byte_enable();
    clear_inputs();
    set_port(0, 32'h10, 1'b0, 4'b0101, 32'h11223344);
    step();
    clear_inputs();
    set_port(0, 32'h10, 1'b1, 4'h0, 32'h0);
    step();
    chk_cnt++; if (o_data[0] !== 32'hDE22BE44 || o_data[0] !== exp_data[0]) $display("FAIL byte_enable: got %h want de22be44", o_data[0]); else pass_cnt++;
  endtask

  task automatic test_conflict();
    int vcount [MP];
    do_reset();
    clear_inputs();
    for (int p = 0; p < MP; p++) begin
      set_port(p, 32'(p * 16), 1'b1, 4'h0, 32'h0);
      vcount[p] = 0;
    end
    for (int k = 0; k < 10; k++) begin
      step();
      chk_cnt++;
      if (o_gnt !== 5'(1 << (k % MP)) || o_gnt !== e_gnt)
        $display("FAIL conflict_gnt[%0d]: got %b want %b", k, o_gnt, 5'(1 << (k % MP)));
      else pass_cnt++;
      for (int p = 0; p < MP; p++) if (o_valid[p] === 1'b1) vcount[p]++;
    end
    chk_cnt++; if (o_cnt !== 16'd10 || o_cnt !== cnt_m) $display("FAIL conflict_cnt: got %0d want 10", o_cnt); else pass_cnt++;
    for (int p = 0; p < MP; p++) begin
      chk_cnt++; if (vcount[p] != 2) $display("FAIL conflict_valid_p%0d: got %0d want 2", p, vcount[p]); else pass_cnt++;
    end
  endtask

  task automatic test_no_conflict();
    clear_inputs();
    for (int p = 0; p < 4; p++) set_port(p, 32'(p * 4), 1'b0, 4'hF, 32'hC0DE_0000 + 32'(p));
    step();
    chk_cnt++; if (o_gnt !== 5'b01111) $display("FAIL noconf_gnt: got %b want 01111", o_gnt); else pass_cnt++;
    chk_cnt++; if (o_valid !== 5'b01111) $display("FAIL noconf_valid: got %b want 01111", o_valid); else pass_cnt++;
    chk_cnt++; if (o_cnt !== 16'd10) $display("FAIL noconf_cnt: got %0d want 10", o_cnt); else pass_cnt++;
    clear_inputs();
    for (int p = 0; p < 4; p++) set_port(p, 32'(p * 4), 1'b1, 4'h0, 32'h0);
    step();
    for (int p = 0; p < 4; p++) begin
      chk_cnt++; if (o_data[p] !== 32'hC0DE_0000 + 32'(p)) $display("FAIL noconf_rd_p%0d: got %h want %h", p, o_data[p], 32'hC0DE_0000 + 32'(p)); else pass_cnt++;
    end
  endtask

  task automatic test_stall_and_wrap();
    clear_inputs();
    stall = 5'b00001;
    set_port(0, 32'h0, 1'b0, 4'hF, 32'hA5A55A5A);
    for (int c = 0; c < 4; c++) begin
      step();
      chk_cnt++; if (o_gnt !== 5'b0 || o_cnt !== 16'd10) $display("FAIL stall[%0d]: got gnt=%b cnt=%0d want gnt=00000 cnt=10", c, o_gnt, o_cnt); else pass_cnt++;
    end
    stall = '0;
    step();
    chk_cnt++; if (o_gnt !== 5'b00001 || o_valid !== 5'b00001) $display("FAIL stall_release: got gnt=%b v=%b want 00001/00001", o_gnt, o_valid); else pass_cnt++;
    clear_inputs();
    set_port(0, 32'h1000, 1'b1, 4'h0, 32'h0);
    set_port(1, 32'hFFFF_F004, 1'b1, 4'h0, 32'h0);
    step();
    chk_cnt++; if (o_data[0] !== 32'hA5A55A5A) $display("FAIL wrap_0x1000: got %h want a5a55a5a", o_data[0]); else pass_cnt++;
    chk_cnt++; if (o_data[1] !== 32'hC0DE0001) $display("FAIL wrap_high: got %h want c0de0001", o_data[1]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    rst = 1'b1;
    set_port(0, 32'h10, 1'b0, 4'hF, 32'h12345678);
    step();
    chk_cnt++; if (o_gnt !== 5'b0 || o_valid !== 5'b0) $display("FAIL rst_mid: got gnt=%b v=%b want 0/0", o_gnt, o_valid); else pass_cnt++;
    rst = 1'b0;
    clear_inputs();
    set_port(0, 32'h10, 1'b1, 4'h0, 32'h0);
    step();
    chk_cnt++; if (o_data[0] !== 32'hDE22BE44) $display("FAIL rst_no_write: got %h want de22be44", o_data[0]); else pass_cnt++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    // Give every word of the small test pool a known value.
    for (int r = 0; r < 4; r++) begin
      clear_inputs();
      for (int p = 0; p < NB; p++) set_port(p, 32'((r * NB + p) * 4), 1'b0, 4'hF, $urandom);
      step();
    end
    exp_q.delete();
    for (int c = 0; c < 300; c++) begin
      clear_inputs();
      for (int p = 0; p < MP; p++) begin
        req[p]   = ($urandom_range(0, 3) != 0);
        wen[p]   = 1'($urandom_range(0, 1));
        be[p]    = 4'($urandom_range(0, 15));
        wdata[p] = $urandom;
        add[p]   = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
        stall[p] = ($urandom_range(0, 7) == 0);
      end
      step();
      chk_cnt++; if (o_gnt !== e_gnt) $display("FAIL rand_gnt[%0d]: got %b want %b", c, o_gnt, e_gnt); else pass_cnt++;
      chk_cnt++; if (o_valid !== exp_valid) $display("FAIL rand_valid[%0d]: got %b want %b", c, o_valid, exp_valid); else pass_cnt++;
      chk_cnt++; if (o_cnt !== cnt_m) $display("FAIL rand_cnt[%0d]: got %0d want %0d", c, o_cnt, cnt_m); else pass_cnt++;
      for (int p = 0; p < MP; p++) begin
        if (o_valid[p] === 1'b1) begin
          chk_cnt++;
          if (exp_q.size() == 0) $display("FAIL rand_data[%0d] p%0d: got %h want nothing queued", c, p, o_data[p]);
          else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (o_data[p] !== e) $display("FAIL rand_data[%0d] p%0d: got %h want %h", c, p, o_data[p], e);
            else pass_cnt++;
          end
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    cnt_m = '0;
    exp_valid = '0;
    for (int b = 0; b < NB; b++) ptr_m[b] = 0;
    for (int p = 0; p < MP; p++) exp_data[p] = '0;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_conflict();
    test_no_conflict();
    test_stall_and_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
